// File: rtl/msgpu_frontend.sv
// msgpu_frontend: MCU byte-bus front end for the MSGPU.
// Synchronizes an asynchronous MCU byte strobe and assembles RGB444 pixels
// from byte pairs into a read-first framebuffer. Also generates a divided
// PSRAM clock.
module msgpu_frontend #(
  parameter int CLOCK_DIV     = 3,
  parameter int FB_ADDR_WIDTH = 12
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        mcu_bus_clock,
  input  logic [7:0]  mcu_bus,
  input  logic        mcu_bus_command_data,
  input  logic [21:0] framebuffer_read_pointer,
  output logic [11:0] read_data,
  output logic        mcu_pixel_clock,
  output logic        mcu_command_clock,
  output logic [7:0]  pixel_data,
  output logic        psram_clock
);

  localparam int DIV_W = (CLOCK_DIV > 2) ? $clog2(CLOCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLOCK_DIV / 2);
  localparam int FB_DEPTH = 1 << FB_ADDR_WIDTH;

  // Synchronizer stages (p1, p2) plus an edge-detect stage (p3) for the strobe.
  logic       strobe_p1, strobe_p2, strobe_p3;
  logic [7:0] bus_p1, bus_p2;
  logic       cmd_p1, cmd_p2;
  // live: synchronizer carries real samples; armed: strobe seen low since reset.
  logic       live, armed;
  logic       strobe_rise;

  logic                     phase;
  logic [FB_ADDR_WIDTH-1:0] wp;
  logic [7:0]               hold;
  logic                     pixel_write;
  logic [11:0]              mem [0:FB_DEPTH-1];

  logic [DIV_W-1:0] div_cnt;

  // Upper read-pointer bits alias onto the framebuffer and are deliberately dropped.
  logic unused_ptr_bits;
  assign unused_ptr_bits = ^framebuffer_read_pointer[21:FB_ADDR_WIDTH];

  // An edge is only accepted once the strobe has been observed low after reset,
  // so a strobe already high at reset release never produces a pulse.
  assign strobe_rise = strobe_p2 & ~strobe_p3 & armed;
  assign pixel_write = strobe_rise & ~cmd_p2 & phase & ~reset;

  // Two-flop synchronizers for strobe, byte and command flag; strobe edge stage.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      strobe_p1 <= 1'b0;
      strobe_p2 <= 1'b0;
      strobe_p3 <= 1'b0;
      bus_p1    <= 8'h00;
      bus_p2    <= 8'h00;
      cmd_p1    <= 1'b0;
      cmd_p2    <= 1'b0;
      live      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      strobe_p1 <= mcu_bus_clock;
      strobe_p2 <= strobe_p1;
      strobe_p3 <= strobe_p2;
      bus_p1    <= mcu_bus;
      bus_p2    <= bus_p1;
      cmd_p1    <= mcu_bus_command_data;
      cmd_p2    <= cmd_p1;
      live      <= 1'b1;
      armed     <= armed | (live & ~strobe_p1);
    end
  end

  // Byte acceptance: strobes, last-byte register, pixel phase and write pointer.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      mcu_pixel_clock   <= 1'b0;
      mcu_command_clock <= 1'b0;
      pixel_data        <= 8'h00;
      phase             <= 1'b0;
      wp                <= '0;
    end else begin
      mcu_pixel_clock   <= strobe_rise & ~cmd_p2;
      mcu_command_clock <= strobe_rise & cmd_p2;
      if (strobe_rise) begin
        pixel_data <= bus_p2;
        if (cmd_p2) begin
          if (bus_p2 == 8'h01) begin
            wp    <= '0;
            phase <= 1'b0;
          end
        end else begin
          phase <= ~phase;
          if (phase) wp <= wp + 1'b1;
        end
      end
    end
  end

  // First byte of a pixel carries {R,G}; held until the B byte arrives.
  always_ff @(posedge system_clock) begin
    if (strobe_rise & ~cmd_p2 & ~phase & ~reset) hold <= bus_p2;
  end

  // Framebuffer write port; contents survive reset.
  always_ff @(posedge system_clock) begin
    if (pixel_write) mem[wp] <= {hold, bus_p2[3:0]};
  end

  // Registered read port, read-first with respect to a same-cycle write.
  always_ff @(posedge system_clock) begin
    if (reset) read_data <= 12'h000;
    else       read_data <= mem[framebuffer_read_pointer[FB_ADDR_WIDTH-1:0]];
  end

  // PSRAM clock divider: high while the counter is in its lower half.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      div_cnt     <= '0;
      psram_clock <= 1'b0;
    end else begin
      psram_clock <= (div_cnt < DIV_HALF);
      div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_msgpu_frontend.sv
// Testbench for msgpu_frontend: a default instance and an FB_ADDR_WIDTH=2
// instance share all inputs; a scoreboard tracks accepted bytes and a model
// tracks both framebuffers.
module tb_msgpu_frontend;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b0;
  logic [7:0]  bus = 8'h00;
  logic        cmd = 1'b0;
  logic [21:0] ptr = 22'h0;

  logic [11:0] rd, rd_s;
  logic        pix, pix_s, cmdp, cmdp_s, psram, psram_s;
  logic [7:0]  pdata, pdata_s;

  always #5 clk = ~clk;

  msgpu_frontend dut (
    .system_clock(clk), .reset(reset), .mcu_bus_clock(strobe), .mcu_bus(bus),
    .mcu_bus_command_data(cmd), .framebuffer_read_pointer(ptr),
    .read_data(rd), .mcu_pixel_clock(pix), .mcu_command_clock(cmdp),
    .pixel_data(pdata), .psram_clock(psram)
  );

  msgpu_frontend #(.FB_ADDR_WIDTH(2)) dut_small (
    .system_clock(clk), .reset(reset), .mcu_bus_clock(strobe), .mcu_bus(bus),
    .mcu_bus_command_data(cmd), .framebuffer_read_pointer(ptr),
    .read_data(rd_s), .mcu_pixel_clock(pix_s), .mcu_command_clock(cmdp_s),
    .pixel_data(pdata_s), .psram_clock(psram_s)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       is_cmd;
    logic [7:0] b;
  } ev_t;
  ev_t sb[$];
  ev_t mon_ev;

  logic [11:0] mb [4096];
  logic [11:0] ms [4];
  logic [11:0] wp_b;
  logic [1:0]  wp_s;
  logic        phase;
  logic [7:0]  hold;

  task automatic model_reset();
    wp_b  = 12'h0;
    wp_s  = 2'h0;
    phase = 1'b0;
  endtask

  task automatic model_byte(input logic c, input logic [7:0] b);
    ev_t e;
    e.is_cmd = c;
    e.b = b;
    sb.push_back(e);
    if (c) begin
      if (b == 8'h01) model_reset();
    end else if (!phase) begin
      hold  = b;
      phase = 1'b1;
    end else begin
      mb[wp_b] = {hold, b[3:0]};
      ms[wp_s] = {hold, b[3:0]};
      wp_b  = wp_b + 12'h1;
      wp_s  = wp_s + 2'h1;
      phase = 1'b0;
    end
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected strobe pulses never seen, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic send_byte(input logic c, input logic [7:0] b);
    model_byte(c, b);
    @(negedge clk);
    bus = b;
    cmd = c;
    repeat (2) @(negedge clk);
    strobe = 1'b1;
    repeat (3) @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    check_drained("send_byte");
  endtask

  task automatic read_check(input logic [21:0] p, input string name);
    @(negedge clk);
    ptr = p;
    @(negedge clk);
    tests++;
    if (rd !== mb[p[11:0]]) begin
      fails++;
      $display("FAIL %s big: read_data=%h required %h", name, rd, mb[p[11:0]]);
    end
    tests++;
    if (rd_s !== ms[p[1:0]]) begin
      fails++;
      $display("FAIL %s small: read_data=%h required %h", name, rd_s, ms[p[1:0]]);
    end
  endtask

  // Scoreboard monitor: every strobe pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (!reset && (pix || cmdp)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: pix=%0b cmd=%0b data=%h, required no pulse", pix, cmdp, pdata);
      end else begin
        mon_ev = sb.pop_front();
        if (pix !== ~mon_ev.is_cmd || cmdp !== mon_ev.is_cmd || pdata !== mon_ev.b) begin
          fails++;
          $display("FAIL strobe_byte: pix=%0b cmd=%0b data=%h, required pix=%0b cmd=%0b data=%h",
                   pix, cmdp, pdata, ~mon_ev.is_cmd, mon_ev.is_cmd, mon_ev.b);
        end
      end
      tests++;
      if ({pix_s, cmdp_s, pdata_s} !== {pix, cmdp, pdata}) begin
        fails++;
        $display("FAIL small_strobe: got %b required %b", {pix_s, cmdp_s, pdata_s}, {pix, cmdp, pdata});
      end
    end
  end

  task automatic test_reset();
    logic exp;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({rd, pix, cmdp, pdata, psram} !== 23'h0) begin
      fails++;
      $display("FAIL reset_outputs big: got %h required 0", {rd, pix, cmdp, pdata, psram});
    end
    tests++;
    if ({rd_s, pix_s, cmdp_s, pdata_s, psram_s} !== 23'h0) begin
      fails++;
      $display("FAIL reset_outputs small: got %h required 0", {rd_s, pix_s, cmdp_s, pdata_s, psram_s});
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp = (k % 3 == 0);
      tests++;
      if (psram !== exp || psram_s !== exp) begin
        fails++;
        $display("FAIL psram_pattern cycle %0d: got %b/%b required %b", k, psram, psram_s, exp);
      end
      tests++;
      if ({pix, cmdp, pdata} !== 10'h0) begin
        fails++;
        $display("FAIL idle_outputs cycle %0d: got %h required 0", k, {pix, cmdp, pdata});
      end
    end
  endtask

  task automatic test_basic();
    send_byte(1'b1, 8'h01);
    send_byte(1'b0, 8'hA5);
    send_byte(1'b0, 8'h0C);
    read_check(22'h0, "basic_pixel0");
    send_byte(1'b1, 8'h7E);
    send_byte(1'b0, 8'h3B);
    send_byte(1'b0, 8'h4D);
    read_check(22'h1, "basic_pixel1");
    read_check(22'h001001, "alias_read");
  endtask

  task automatic test_wrap();
    logic [7:0] hi [5];
    logic [7:0] lo [5];
    hi = '{8'h12, 8'h45, 8'h78, 8'h9A, 8'hCD};
    lo = '{8'h03, 8'h06, 8'h09, 8'h0B, 8'h0E};
    send_byte(1'b1, 8'h01);
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b0, hi[i]);
      send_byte(1'b0, lo[i]);
    end
    for (int i = 0; i < 5; i++) read_check(22'(i), "wrap_read");
  endtask

  task automatic test_reset_midpixel();
    send_byte(1'b0, 8'hFF);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(1'b0, 8'h12);
    send_byte(1'b0, 8'h03);
    read_check(22'h0, "midpixel_drop");
    read_check(22'h1, "mem_survives_reset");
  endtask

  task automatic test_strobe_hold();
    int cnt;
    int pos;
    cnt = 0;
    pos = -1;
    model_byte(1'b0, 8'h5A);
    @(negedge clk);
    bus = 8'h5A;
    cmd = 1'b0;
    repeat (2) @(negedge clk);
    strobe = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (pix) begin
        cnt++;
        if (pos < 0) pos = k;
      end
    end
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (cnt !== 1) begin
      fails++;
      $display("FAIL hold_pulse_count: got %0d required 1", cnt);
    end
    tests++;
    if (pos !== 3) begin
      fails++;
      $display("FAIL hold_pulse_latency: got cycle %0d required 3", pos);
    end
    check_drained("strobe_hold");
    send_byte(1'b0, 8'h06);
    read_check(22'h1, "hold_pixel");
  endtask

  task automatic test_strobe_during_reset();
    int cnt;
    cnt = 0;
    @(negedge clk);
    bus = 8'h77;
    cmd = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    strobe = 1'b1;
    model_reset();
    repeat (4) @(negedge clk) if (pix || cmdp) cnt++;
    reset = 1'b0;
    repeat (6) @(negedge clk) if (pix || cmdp) cnt++;
    strobe = 1'b0;
    repeat (4) @(negedge clk) if (pix || cmdp) cnt++;
    tests++;
    if (cnt !== 0) begin
      fails++;
      $display("FAIL strobe_over_reset: got %0d pulses required 0", cnt);
    end
    send_byte(1'b0, 8'hC3);
    send_byte(1'b0, 8'h0D);
    read_check(22'h0, "after_reset_strobe");
  endtask

  task automatic test_read_first();
    logic [11:0] old_b, old_s, new_b, new_s;
    logic found;
    send_byte(1'b0, 8'h9C);
    @(negedge clk);
    ptr = 22'h1;
    old_b = mb[1];
    old_s = ms[1];
    model_byte(1'b0, 8'h0E);
    new_b = mb[1];
    new_s = ms[1];
    bus = 8'h0E;
    cmd = 1'b0;
    repeat (2) @(negedge clk);
    strobe = 1'b1;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (pix && !found) begin
        found = 1'b1;
        tests++;
        if (rd !== old_b || rd_s !== old_s) begin
          fails++;
          $display("FAIL read_first_old: got %h/%h required %h/%h", rd, rd_s, old_b, old_s);
        end
        @(negedge clk);
        tests++;
        if (rd !== new_b || rd_s !== new_s) begin
          fails++;
          $display("FAIL read_first_new: got %h/%h required %h/%h", rd, rd_s, new_b, new_s);
        end
      end
    end
    strobe = 1'b0;
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL read_first_timeout: pulse seen=%0b required 1", found);
    end
    repeat (4) @(negedge clk);
    check_drained("read_first");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_reset_midpixel();
    test_strobe_hold();
    test_strobe_during_reset();
    test_read_first();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/msgpu_frontend.md
MSGPU_FRONTEND -- requirements
Module: msgpu_frontend

Interface
REQ-001 Parameter CLOCK_DIV, default 3: psram_clock division ratio; legal values are 2 and above.
REQ-002 Parameter FB_ADDR_WIDTH, default 12: framebuffer depth is 2^FB_ADDR_WIDTH words of 12 bits.
REQ-003 Port system_clock, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port mcu_bus_clock, input, 1 bit: asynchronous MCU byte strobe; the byte is taken on its rising edge.
REQ-006 Port mcu_bus, input, 8 bits: MCU byte.
REQ-007 Port mcu_bus_command_data, input, 1 bit: 1 = command byte, 0 = pixel byte.
REQ-008 Port framebuffer_read_pointer, input, 22 bits: read word address.
REQ-009 Port read_data, output, 12 bits: pixel read as {R[3:0],G[3:0],B[3:0]}.
REQ-010 Port mcu_pixel_clock, output, 1 bit: one-cycle pulse when a pixel byte is accepted.
REQ-011 Port mcu_command_clock, output, 1 bit: one-cycle pulse when a command byte is accepted.
REQ-012 Port pixel_data, output, 8 bits: last accepted byte, either kind.
REQ-013 Port psram_clock, output, 1 bit: divided clock.

Function
REQ-014 mcu_bus_clock, mcu_bus and mcu_bus_command_data SHALL each pass through two synchronizing flops.
- A rising edge is detected as stage2=1 while stage3=0.
REQ-015 A detected edge SHALL register pixel_data from the synchronized bus.
- It SHALL also pulse exactly one strobe for one cycle: mcu_command_clock if the synchronized command_data is 1, otherwise mcu_pixel_clock.
- Latency: the pulse is high in the 3rd cycle after the first system_clock edge that samples mcu_bus_clock high.
REQ-016 MCU timing contract: mcu_bus_clock high ≥2 and low ≥2 system_clock periods; bus and command_data stable from 1 cycle before to 3 cycles after the strobe rising edge. At most one pulse per strobe edge.
REQ-017 Pixel assembly uses a phase bit and a write pointer wp of FB_ADDR_WIDTH bits.
- Pixel byte in phase 0: store it as {R,G} = byte[7:4], byte[3:0]; set phase to 1.
- Pixel byte in phase 1: write {R,G,byte[3:0]} to mem[wp]; wp increments; phase returns to 0.
REQ-018 wp SHALL wrap from 2^FB_ADDR_WIDTH−1 to 0.
REQ-019 Command byte 8'h01 SHALL set wp=0 and phase=0 in the pulse cycle. All other command values SHALL only pulse mcu_command_clock, with no internal effect.
REQ-020 Read: read_data <= mem[framebuffer_read_pointer[FB_ADDR_WIDTH-1:0]] every cycle, one-cycle latency. Upper pointer bits SHALL be ignored (aliasing).
REQ-021 A simultaneous read and write to the same address SHALL return the old contents (read-first). The new data is visible on the next read.
REQ-022 Divider: counter counts 0..CLOCK_DIV−1 and wraps. psram_clock SHALL be registered high when counter < CLOCK_DIV/2 (integer division), otherwise low. Default duty is 1 high cycle in 3.
REQ-023 Memory contents are undefined at power-up.

Reset
REQ-024 While reset=1 at a clock edge, the following SHALL be 0: all synchronizer flops, phase, wp, divider counter, read_data, pixel_data, psram_clock, mcu_pixel_clock, mcu_command_clock.
REQ-025 Reset SHALL NOT clear memory contents.
REQ-026 Reset asserted mid-pixel (phase 1) SHALL discard the held half-pixel.
REQ-027 A strobe edge in flight during reset SHALL produce no pulse. A strobe already high when reset releases SHALL NOT be detected as an edge.
REQ-028 First psram_clock high is in the cycle after reset deasserts.

Verification
REQ-029 Reset, then hold mcu_bus_clock low 10 cycles -> all outputs 0, no pulses; psram_clock pattern 1,0,0 repeating with period 3.
REQ-030 Command 8'h01, then pixel bytes 8'hA5 and 8'h0C, then framebuffer_read_pointer=0 -> mcu_command_clock pulses once; read_data=12'hA5C one cycle after the pointer is applied.
REQ-031 With FB_ADDR_WIDTH=2, write 5 pixels p0..p4 -> mem[0]=p4, mem[1..3]=p1..p3; framebuffer_read_pointer=22'h000004 reads mem[0].
REQ-032 Pixel byte 8'hFF, reset pulse, then pixels 8'h12 and 8'h03 -> mem[0]=12'h123, showing the half-pixel was dropped.
REQ-033 Strobe held high 20 cycles -> exactly one mcu_pixel_clock pulse, in the 3rd cycle after the strobe is first sampled high.
REQ-034 Read and write the same address in the same cycle -> read_data shows the old value, then the new value on the following read.
